// File: rtl/ula_datapath_mc.sv
// Multicycle datapath: register file, reg/immediate operand mux and ULA,
// sequenced IDLE -> READ -> EXEC -> WB with start/busy/done handshake.
module ula_datapath_mc #(
  parameter int DATA_WIDTH = 8,
  parameter int REG_COUNT  = 8,
  parameter int ADDR_WIDTH = $clog2(REG_COUNT),
  parameter int ZERO_REG   = 1
) (
  input  logic                  clock_reg,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic                  use_imm,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic                  ext_we,
  input  logic [ADDR_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_data,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  carry,
  output logic                  overflow,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int SH_W = $clog2(DATA_WIDTH);
  localparam int MSB  = DATA_WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
  logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
  logic [2:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                  use_imm_q, use_imm_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH:0]   sum_s, diff_s;
  logic [DATA_WIDTH-1:0] alu_res_s;
  logic                  alu_c_s, alu_v_s;

  // ULA: pure function of the latched operands and opcode.
  always_comb begin
    sum_s     = {1'b0, a_q} + {1'b0, b_q};
    diff_s    = {1'b0, a_q} - {1'b0, b_q};
    alu_res_s = '0;
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (op_q)
      3'd0: begin
        alu_res_s = sum_s[MSB:0];
        alu_c_s   = sum_s[DATA_WIDTH];
        alu_v_s   = (a_q[MSB] == b_q[MSB]) && (sum_s[MSB] != a_q[MSB]);
      end
      3'd1: begin
        alu_res_s = diff_s[MSB:0];
        // diff_s top bit is the borrow; carry means "no borrow"
        alu_c_s   = ~diff_s[DATA_WIDTH];
        alu_v_s   = (a_q[MSB] != b_q[MSB]) && (diff_s[MSB] != a_q[MSB]);
      end
      3'd2:    alu_res_s = a_q & b_q;
      3'd3:    alu_res_s = a_q | b_q;
      3'd4:    alu_res_s = a_q ^ b_q;
      3'd5:    alu_res_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      3'd6:    alu_res_s = a_q << b_q[SH_W-1:0];
      3'd7:    alu_res_s = a_q >> b_q[SH_W-1:0];
      default: alu_res_s = '0;
    endcase
  end

  // Next-state, operand capture and register-file write selection.
  always_comb begin
    state_d   = state_q;
    regs_d    = regs_q;
    op_d      = op_q;
    rd_d      = rd_q;
    use_imm_d = use_imm_q;
    imm_d     = imm_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ext_we && !((ZERO_REG != 0) && (ext_addr == '0))) begin
          regs_d[ext_addr] = ext_data;
        end else begin
          regs_d = regs_q;
        end
        if (start) begin
          op_d      = op;
          rd_d      = rd_addr;
          use_imm_d = use_imm;
          imm_d     = imm;
          state_d   = S_READ;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_READ: begin
        a_d     = regs_q[rs1_addr];
        b_d     = use_imm_q ? imm_q : regs_q[rs2_addr];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        result_d = alu_res_s;
        zero_d   = (alu_res_s == '0);
        carry_d  = alu_c_s;
        ovf_d    = alu_v_s;
        state_d  = S_WB;
      end
      S_WB: begin
        if (!((ZERO_REG != 0) && (rd_q == '0))) begin
          regs_d[rd_q] = result_q;
        end else begin
          regs_d = regs_q;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock_reg) begin
    if (reset) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      op_q      <= 3'd0;
      rd_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      regs_q    <= regs_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      use_imm_q <= use_imm_d;
      imm_q     <= imm_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign dbg_data = ((ZERO_REG != 0) && (dbg_addr == '0)) ? '0 : regs_q[dbg_addr];

endmodule
